// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer sitting beside the single-cycle ALU.
// Signed multiply runs as an unsigned shift-add over operand magnitudes and
// signed divide as a restoring divide; both take WIDTH iterations and
// finish with a sign-correction cycle that writes HI/LO.
module alu_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl_operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cancel,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1)
    // which is exactly representable as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    logic [1:0]         state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    // MULT: {partial product high, multiplier shifting out}.
    // DIV : {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    // MULT: |multiplicand|; DIV: |divisor|.
    logic [WIDTH-1:0]   opnd_q,    opnd_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q,  is_div_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               dbz_q,     dbz_d;
    logic               busy_q;
    logic               done_q;

    logic               idle_or_done_s;
    logic               valid_op_s;
    logic               accept_s;
    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     cand_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    // Acceptance qualification and one iteration of each datapath.
    always_comb begin
        idle_or_done_s = (state_q == S_IDLE) || (state_q == S_DONE);
        valid_op_s     = (ALUControl_operation == OP_MULT) ||
                         (ALUControl_operation == OP_DIV);
        accept_s       = idle_or_done_s && start && valid_op_s && !cancel;

        addend_s   = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
        sum_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
        mul_next_s = {sum_s, acc_q[WIDTH-1:1]};

        cand_s     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff_s     = cand_s - {1'b0, opnd_q};
        rem_next_s = diff_s[WIDTH] ? cand_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
        div_next_s = {rem_next_s, acc_q[WIDTH-2:0], ~diff_s[WIDTH]};

        prod_s     = neg_res_q ? -acc_q : acc_q;
        quo_fix_s  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix_s  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and datapath register updates for the sequencer FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    is_div_d  = (ALUControl_operation == OP_DIV);
                    neg_res_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    neg_rem_d = operand_a[WIDTH-1];
                    cnt_d     = {CW{1'b0}};
                    dbz_d     = 1'b0;
                    if (ALUControl_operation == OP_DIV) begin
                        acc_d  = {{WIDTH{1'b0}}, magnitude(operand_a)};
                        opnd_d = magnitude(operand_b);
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, magnitude(operand_b)};
                        opnd_d = magnitude(operand_a);
                    end
                    if ((ALUControl_operation == OP_DIV) &&
                        (operand_b == {WIDTH{1'b0}})) begin
                        // Divide by zero completes immediately.
                        hi_d    = operand_a;
                        lo_d    = {WIDTH{1'b1}};
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next_s : mul_next_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIXUP;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_FIXUP: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        hi_d = rem_fix_s;
                        lo_d = quo_fix_s;
                    end else begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            opnd_q    <= {WIDTH{1'b0}};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
            busy_q    <= (state_d == S_RUN) || (state_d == S_FIXUP);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign stall       = busy_q | (start & valid_op_s & idle_or_done_s);

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed scoreboard bench for alu_muldiv_sequencer (WIDTH = 32).
module tb_alu_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         cancel;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         stall;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W:0] sb_q[$];     // {div_by_zero, hi, lo}
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    alu_muldiv_sequencer #(.WIDTH(W)) dut (
        .clock                (clock),
        .reset                (reset),
        .start                (start),
        .ALUControl_operation (op),
        .operand_a            (a),
        .operand_b            (b),
        .cancel               (cancel),
        .busy                 (busy),
        .stall                (stall),
        .done                 (done),
        .div_by_zero          (div_by_zero),
        .hi                   (hi),
        .lo                   (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result from 64-bit signed arithmetic.
    function automatic logic [2*W:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        logic [63:0] qv;
        logic [63:0] rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == OP_MULT) begin
            q = sx * sy;
            p = q;
            return {1'b0, p};
        end
        if (y == '0) return {1'b1, x, {W{1'b1}}};
        q  = sx / sy;
        r  = sx % sy;
        qv = q;
        rv = r;
        return {1'b0, rv[W-1:0], qv[W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a valid request for one edge, then scramble the operands.
    task automatic launch(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit expect_result);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (expect_result) sb_q.push_back(model(o, x, y));
        #1;
        check("stall_on_start", {63'd0, stall}, 64'd1);
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
        int lat;
        int nb;
        logic [2*W:0] e;
        lat = 0;
        nb  = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) nb++;
            if (lat == 10) check({tag, "_hold"}, {hi, lo}, {last_hi, last_lo});
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_hi"}, 64'(hi), 64'(e[2*W-1:W]));
            check({tag, "_lo"}, 64'(lo), 64'(e[W-1:0]));
            check({tag, "_dbz"}, 64'(div_by_zero), 64'(e[2*W]));
            last_hi = e[2*W-1:W];
            last_lo = e[W-1:0];
        end
    endtask

    initial begin
        int done_seen;
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 4'b0000;
        a      = '0;
        b      = '0;
        tick();
        tick();
        check("reset_outputs", {hi, lo}, 64'd0);
        check("reset_status", {60'd0, busy, done, div_by_zero, stall}, 64'd0);
        reset = 1'b0;
        tick();

        // Main arithmetic, several chained back to back from the done cycle.
        launch(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
        wait_done("mult_7_m3", 33, 33);
        check("mult_7_m3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        wait_done("div_m7_2", 33, 33);
        check("div_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("div_min_m1", 33, 33);
        check("div_min_m1_const", {hi, lo}, 64'h0000_0000_8000_0000);
        launch(OP_DIV, 32'h0000_0005, 32'h0000_0000, 1'b1);
        wait_done("div_5_0", 0, 0);
        launch(OP_MULT, 32'h0000_0003, 32'h0000_0004, 1'b1);
        check("dbz_cleared", {63'd0, div_by_zero}, 64'd0);
        wait_done("mult_3_4_b2b", 33, 33);

        // Done is a single pulse when no further start arrives.
        tick();
        check("done_pulse_width", {62'd0, done, busy}, 64'd0);
        launch(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("mult_m1_m1", 33, 33);
        launch(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1);
        wait_done("div_100_m7", 33, 33);
        launch(OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
        wait_done("div_m100_m7", 33, 33);

        // Invalid opcode in DONE is ignored and the FSM falls back to IDLE.
        op    = 4'b0101;
        start = 1'b1;
        #1;
        check("invalid_op_stall", {63'd0, stall}, 64'd0);
        tick();
        start = 1'b0;
        check("invalid_op_ignored", {62'd0, busy, done}, 64'd0);

        // Cancel at RUN iteration 10.
        launch(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_idle", {62'd0, busy, done}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        check("cancel_no_done", 64'(done_seen), 64'd0);
        check("cancel_hold", {hi, lo}, {last_hi, last_lo});

        // Start together with cancel is not accepted.
        op     = OP_MULT;
        a      = 32'h0000_0009;
        b      = 32'h0000_0009;
        start  = 1'b1;
        cancel = 1'b1;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        check("start_cancel_busy", {63'd0, busy}, 64'd0);
        tick();
        check("start_cancel_done", {63'd0, done}, 64'd0);
        check("start_cancel_hold", {hi, lo}, {last_hi, last_lo});

        // Asynchronous reset in the middle of a run.
        launch(OP_MULT, 32'h0000_0003, 32'h0000_0004, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_result", {hi, lo}, 64'd0);
        check("async_reset_status", {61'd0, busy, done, div_by_zero}, 64'd0);
        last_hi = '0;
        last_lo = '0;
        tick();
        reset = 1'b0;
        op    = 4'b0000;
        start = 1'b1;
        #1;
        check("op0_stall", {63'd0, stall}, 64'd0);
        tick();
        start = 1'b0;
        check("op0_no_change", {62'd0, busy, done}, 64'd0);
        check("op0_hold", {hi, lo}, 64'd0);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
